// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if: 4-bit character-LCD write bus (E, RS, RW, D[11:8]) between driver and responder
interface lcd_bus_receiver_if;
  logic iLCD_Enabled;
  logic iLCD_RegisterSelect;
  logic iLCD_ReadWrite;
  logic [3:0] iLCD_Data;
  modport master(output iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data);
  modport slave(input iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data);
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: LCD-side responder that assembles nibbles into bytes and checks HD44780 init and timing rules
module lcd_bus_receiver #(
  parameter int POWERON_CYCLES = 750000,
  parameter int INIT2_GAP = 205000,
  parameter int INIT3_GAP = 5000,
  parameter int CMD_GAP = 2000,
  parameter int NIBBLE_GAP = 50,
  parameter int CLEAR_GAP = 82000,
  parameter int E_MIN_CYCLES = 12
) (
  input  logic Clock,
  input  logic Reset,
  lcd_bus_receiver_if.slave lcdBus,
  output logic [7:0] oByte,
  output logic oByteIsData,
  output logic oByteValid,
  output logic oInitDone,
  output logic oErrTiming,
  output logic oErrSequence
);
  typedef enum logic [2:0] {S_POWERON, S_INIT2, S_INIT3, S_INIT4, S_HIGH, S_LOW} state_t;
  state_t state, stateNext;
  logic rE, rise, fall, capRs, hiRs, seqBad, initOk;
  logic [3:0] capNibble, hiNibble;
  logic [7:0] byteNext;
  logic [23:0] gap, reqGap, reqNext;
  logic [15:0] width;
  assign rise = lcdBus.iLCD_Enabled & ~rE;
  assign fall = ~lcdBus.iLCD_Enabled & rE;
  assign byteNext = {hiNibble, capNibble};
  assign initOk = !capRs && capNibble == ((state == S_INIT4) ? 4'h2 : 4'h3);
  always_ff @(posedge Clock)
    state <= Reset ? S_POWERON : stateNext;
  // Wrong init nibbles keep the state and its gap requirement; only a fall ever advances.
  always_comb begin
    stateNext = state;
    reqNext = reqGap;
    seqBad = 1'b0;
    if (fall)
      case (state)
        S_POWERON: if (initOk) begin stateNext = S_INIT2; reqNext = 24'(INIT2_GAP); end else seqBad = 1'b1;
        S_INIT2: if (initOk) begin stateNext = S_INIT3; reqNext = 24'(INIT3_GAP); end else seqBad = 1'b1;
        S_INIT3: if (initOk) begin stateNext = S_INIT4; reqNext = 24'(CMD_GAP); end else seqBad = 1'b1;
        S_INIT4: if (initOk) begin stateNext = S_HIGH; reqNext = 24'(CMD_GAP); end else seqBad = 1'b1;
        S_HIGH: begin stateNext = S_LOW; reqNext = 24'(NIBBLE_GAP); end
        S_LOW: begin
          stateNext = S_HIGH;
          reqNext = (!hiRs && byteNext == 8'h01) ? 24'(CLEAR_GAP) : 24'(CMD_GAP);
          seqBad = capRs != hiRs;
        end
        default: stateNext = S_POWERON;
      endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rE <= 1'b0;
      gap <= '0;
      reqGap <= 24'(POWERON_CYCLES);
      width <= '0;
      capNibble <= '0;
      capRs <= 1'b0;
      hiNibble <= '0;
      hiRs <= 1'b0;
      oByte <= '0;
      oByteIsData <= 1'b0;
      oByteValid <= 1'b0;
      oInitDone <= 1'b0;
      oErrTiming <= 1'b0;
      oErrSequence <= 1'b0;
    end else begin
      rE <= lcdBus.iLCD_Enabled;
      reqGap <= reqNext;
      gap <= fall ? '0 : (&gap ? gap : gap + 1'b1);
      if (lcdBus.iLCD_Enabled) begin
        width <= rise ? 16'd1 : (&width ? width : width + 1'b1);
        capNibble <= lcdBus.iLCD_Data;
        capRs <= lcdBus.iLCD_RegisterSelect;
      end
      if (fall && state == S_HIGH) begin
        hiNibble <= capNibble;
        hiRs <= capRs;
      end
      oByteValid <= fall && state == S_LOW;
      if (fall && state == S_LOW) begin
        oByte <= byteNext;
        oByteIsData <= hiRs;
      end
      if (fall && state == S_INIT4 && initOk) oInitDone <= 1'b1;
      if ((rise && gap < reqGap) || (fall && width < 16'(E_MIN_CYCLES))) oErrTiming <= 1'b1;
      if (seqBad || (lcdBus.iLCD_Enabled && lcdBus.iLCD_ReadWrite)) oErrSequence <= 1'b1;
    end
  end
endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Synthesizable responder for the Spartan-3E character-LCD 4-bit write bus. It is the LCD-side end of the interface that our LCD control block drives.
- Decodes E-strobed nibbles into command and data bytes, and tracks the HD44780 power-on init sequence (0x3, 0x3, 0x3, 0x2).
- Checks every protocol timing minimum and flags violations.
- Used on-chip and in benches as a checker/loopback for the LCD driver. All bus inputs are in the Clock domain (50 MHz).

Parameters:
- POWERON_CYCLES, 750000, minimum cycles from reset release to the first E rise.
- INIT2_GAP, 205000, minimum cycles from init write 1 falling edge to init write 2 rising edge.
- INIT3_GAP, 5000, minimum gap from init write 2 to init write 3.
- CMD_GAP, 2000, minimum gap after init write 3, after init write 4, and after any completed byte.
- NIBBLE_GAP, 50, minimum gap between the high and low nibble of one byte.
- CLEAR_GAP, 82000, minimum gap after command byte 0x01.
- E_MIN_CYCLES, 12, minimum E high width in cycles.

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- iLCD_Enabled  in  1  LCD_E strobe.
- iLCD_RegisterSelect  in  1  0 = command, 1 = data.
- iLCD_ReadWrite  in  1  must be 0; reads are unsupported.
- iLCD_Data  in  4  SF_D<11:8> nibble.
- oByte  out  8  last assembled byte.
- oByteIsData  out  1  RS of the last byte, taken from its high nibble.
- oByteValid  out  1  one-cycle strobe marking a new byte.
- oInitDone  out  1  high once the 4-bit init sequence has completed.
- oErrTiming  out  1  sticky timing-violation flag.
- oErrSequence  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: all outputs 0; state S_POWERON; gap counter 0; E history register 0.
- Reset wins over any bus activity in the same cycle. Reset mid-byte discards the pending high nibble and emits no oByteValid.
- Edge detection:
  - rE holds iLCD_Enabled registered once.
  - Rise = iLCD_Enabled & ~rE; fall = ~iLCD_Enabled & rE.
  - Nibble and RS are captured from the last cycle E was sampled high, i.e. registered copies taken each cycle while E is high.
- Pulse width: a width counter counts cycles E is high. At fall, if width < E_MIN_CYCLES, set oErrTiming.
- Gap counter (24 bits):
  - Cleared at every fall; otherwise increments, saturating at 2^24-1.
  - In S_POWERON it counts from reset release.
  - At each rise it is compared with the required gap for the current state, held in a register. If gap < required, set oErrTiming.
  - The event is still processed after a timing violation; timing errors never alter the state machine.
- Write check: iLCD_ReadWrite=1 in any cycle with E high sets oErrSequence.
- State machine (advances on fall only):
  - S_POWERON, requires POWERON_CYCLES: nibble 0x3 -> S_INIT2, requires INIT2_GAP.
  - S_INIT2: 0x3 -> S_INIT3, requires INIT3_GAP.
  - S_INIT3: 0x3 -> S_INIT4, requires CMD_GAP.
  - S_INIT4: 0x2 -> S_HIGH, requires CMD_GAP; oInitDone=1 from the same edge, stays high until reset.
  - Any init state with a wrong nibble or RS=1: set oErrSequence and stay in the same state. The gap requirement is unchanged, measured from the new fall.
  - S_HIGH: store nibble as byte[7:4] and store RS -> S_LOW, requires NIBBLE_GAP.
  - S_LOW: byte[3:0] = nibble. If RS differs from the stored RS, set oErrSequence but still emit.
    - Registered at the clock edge that samples the fall: oByte, oByteIsData update and oByteValid=1 for exactly one cycle.
    - -> S_HIGH. Requires CLEAR_GAP if the byte is a command equal to 0x01, else CMD_GAP.
- Error flags: oErrTiming and oErrSequence, once set, hold until Reset.
- No other output changes occur outside these rules. oByte holds its value between strobes.

Test Plan:
- Nominal init: writes at 760000, +210000, +6000, +2500 cycles with 12-cycle E pulses -> oInitDone=1 after the fourth fall; both error flags 0; oByteValid never pulses.
- After init, command 0x28 as nibbles 0x2 then 0x8, 60 cycles apart, RS=0 -> oByte=0x28, oByteIsData=0, oByteValid high one cycle at the second fall; no errors.
- Data 0x41 with RS=1, next high nibble only 1000 cycles later -> 0x41 emitted with oByteIsData=1; oErrTiming=1 at the next rise.
- Command 0x01, then a byte written 10000 cycles later -> oErrTiming=1. Repeat with an 83000-cycle gap -> no error.
- E pulse of 8 cycles on the first init write -> oErrTiming=1. Init write 2 with nibble 0x5 -> oErrSequence=1, state stays S_INIT2, and a following correct 0x3 advances the sequence.
- Reset asserted one cycle after a high-nibble fall -> all outputs 0; the following low nibble produces no oByteValid; first E rise before 750000 cycles -> oErrTiming=1.
